// File: rtl/phase_sel_gen.sv
// phase_sel_gen: phase-accumulator select generator for the fractional clock synthesiser.
//
// On each enabled cycle the accumulator adds cur_step. The upper SEL_W+1 accumulator bits
// are decoded into even-mux and odd-mux phase selects. A new step is taken in through a
// valid/ready handshake. It is committed only on an accumulator wrap (or while idle), so the
// phase sequence never glitches.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        accumulate enable
//   clr       synchronous clear of accumulator and pending step (priority over en/handshake)
//   step_in   new step value
//   step_vld  step_in valid
//   step_rdy  block can accept a step (no step pending)
//   even_sel  even-clock mux select
//   odd_sel   odd-clock mux select
//   wrap      one-cycle pulse when the accumulator carried out
//   cur_step  step currently in use
//
// Configuration macro PHASE_SEL_GEN_OUT_REG_EN: when defined, even_sel, odd_sel and wrap
// each pass through one extra output register (reset 0), which adds one cycle of latency.
// cur_step and step_rdy are unaffected.

module phase_sel_gen #(
  parameter int unsigned      ACC_W    = 8,
  parameter int unsigned      SEL_W    = 3,
  parameter logic [ACC_W-1:0] STEP_RST = 'h10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] step_in,
  input  logic             step_vld,
  output logic             step_rdy,
  output logic [SEL_W-1:0] even_sel,
  output logic [SEL_W-1:0] odd_sel,
  output logic             wrap,
  output logic [ACC_W-1:0] cur_step
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] cur_step_q;
  logic [ACC_W-1:0] pend_step_q;
  logic             pend_q;
  logic             wrap_q;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             commit;
  logic             load;
  logic [SEL_W:0]   u;
  logic [SEL_W-1:0] odd_c;
  logic [SEL_W-1:0] even_c;

  assign sum   = {1'b0, acc_q} + {1'b0, cur_step_q};
  assign carry = sum[ACC_W];

  // Commit only on a wrap boundary while running, or at any edge while idle.
  assign commit = pend_q & (~en | carry);
  // A load cannot coincide with a commit, because step_rdy is low while a step is pending.
  assign load   = step_vld & ~pend_q;

  // The even select is the odd select rounded up by the next-lower bit. It wraps to 0 at all-ones.
  assign u      = acc_q[ACC_W-1 -: SEL_W+1];
  assign odd_c  = u[SEL_W:1];
  assign even_c = u[SEL_W:1] + SEL_W'(u[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cur_step_q  <= STEP_RST;
      pend_step_q <= '0;
      pend_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else if (clr) begin
      // The pending step is discarded. cur_step is kept.
      acc_q  <= '0;
      wrap_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (en) begin
        acc_q  <= sum[ACC_W-1:0];
        wrap_q <= carry;
      end else begin
        wrap_q <= 1'b0;
      end
      if (commit) begin
        cur_step_q <= pend_step_q;
        pend_q     <= 1'b0;
      end else if (load) begin
        pend_step_q <= step_in;
        pend_q      <= 1'b1;
      end
    end
  end

  assign step_rdy = ~pend_q;
  assign cur_step = cur_step_q;

`ifdef PHASE_SEL_GEN_OUT_REG_EN
  logic [SEL_W-1:0] even_sel_q;
  logic [SEL_W-1:0] odd_sel_q;
  logic             wrap_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_sel_q <= '0;
      odd_sel_q  <= '0;
      wrap_out_q <= 1'b0;
    end else begin
      even_sel_q <= even_c;
      odd_sel_q  <= odd_c;
      wrap_out_q <= wrap_q;
    end
  end

  assign even_sel = even_sel_q;
  assign odd_sel  = odd_sel_q;
  assign wrap     = wrap_out_q;
`else
  assign even_sel = even_c;
  assign odd_sel  = odd_c;
  assign wrap     = wrap_q;
`endif

endmodule

// File: tb/tb_phase_sel_gen.sv
// Self-checking bench for phase_sel_gen (ACC_W=8, SEL_W=3).
// A behavioural model tracks the accumulator and step handshake with plain integer arithmetic.
// A negedge process compares every output against that model. Directed scenarios add
// hand-computed literal checks at the points of interest.

module tb_phase_sel_gen;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned SEL_W = 3;
`ifdef PHASE_SEL_GEN_OUT_REG_EN
  localparam int Lag = 1;
`else
  localparam int Lag = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [ACC_W-1:0] step_in = '0;
  logic             step_vld = 1'b0;
  logic             step_rdy;
  logic [SEL_W-1:0] even_sel;
  logic [SEL_W-1:0] odd_sel;
  logic             wrap;
  logic [ACC_W-1:0] cur_step;

  int total = 0;
  int bad = 0;

  phase_sel_gen #(
    .ACC_W   (ACC_W),
    .SEL_W   (SEL_W),
    .STEP_RST(8'h10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .step_in (step_in),
    .step_vld(step_vld),
    .step_rdy(step_rdy),
    .even_sel(even_sel),
    .odd_sel (odd_sel),
    .wrap    (wrap),
    .cur_step(cur_step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Select decode from the accumulator value, expressed arithmetically.
  function automatic int odd_of(input int a);
    return (a >> (ACC_W - SEL_W)) % (1 << SEL_W);
  endfunction
  function automatic int even_of(input int a);
    int u;
    u = a >> (ACC_W - SEL_W - 1);
    return ((u >> 1) + (u & 1)) % (1 << SEL_W);
  endfunction

  // Behavioural model
  int m_acc = 0, m_step = 'h10, m_pend = 0, m_pend_step = 0, m_wrap = 0;
  int m_even_d = 0, m_odd_d = 0, m_wrap_d = 0;
  int m_sum;
  always_comb m_sum = m_acc + m_step;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= 0; m_step <= 'h10; m_pend <= 0; m_pend_step <= 0; m_wrap <= 0;
      m_even_d <= 0; m_odd_d <= 0; m_wrap_d <= 0;
    end else begin
      m_even_d <= even_of(m_acc);
      m_odd_d  <= odd_of(m_acc);
      m_wrap_d <= m_wrap;
      if (clr) begin
        m_acc <= 0; m_wrap <= 0; m_pend <= 0;
      end else begin
        if (en) begin
          m_acc  <= m_sum % 256;
          m_wrap <= (m_sum >= 256) ? 1 : 0;
        end else begin
          m_wrap <= 0;
        end
        if (m_pend != 0 && (!en || m_sum >= 256)) begin
          m_step <= m_pend_step; m_pend <= 0;
        end else if (step_vld && m_pend == 0) begin
          m_pend_step <= int'(step_in); m_pend <= 1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("m_even", int'(even_sel), (Lag != 0) ? m_even_d : even_of(m_acc));
    check("m_odd",  int'(odd_sel),  (Lag != 0) ? m_odd_d  : odd_of(m_acc));
    check("m_wrap", int'(wrap),     (Lag != 0) ? m_wrap_d : m_wrap);
    check("m_step", int'(cur_step), m_step);
    check("m_rdy",  int'(step_rdy), (m_pend != 0) ? 0 : 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps;
    // Reset state
    @(negedge clk);
    #1;
    check("rst_even", int'(even_sel), 0);
    check("rst_odd",  int'(odd_sel),  0);
    check("rst_wrap", int'(wrap),     0);
    check("rst_step", int'(cur_step), 'h10);
    check("rst_rdy",  int'(step_rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: free run with default step 0x10
    en = 1'b1;
    wraps = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (wrap) wraps++;
      if (i == 3 + Lag) begin
        check("t1_odd_30",  int'(odd_sel),  1);
        check("t1_even_30", int'(even_sel), 2);
      end
      if (i == 15 + Lag) begin
        check("t1_odd_f0",  int'(odd_sel),  7);
        check("t1_even_f0", int'(even_sel), 0);
      end
      if (i == 16 + Lag) check("t1_wrap", int'(wrap), 1);
    end
    check("t1_wrap_count", wraps, (Lag != 0) ? 1 : 2);

    // 2: step load at acc=0x40, commit on the wrap edge
    repeat (4) tick();
    step_in = 8'h20; step_vld = 1'b1;
    tick();
    step_vld = 1'b0;
    check("t2_rdy_low", int'(step_rdy), 0);
    check("t2_step_old", int'(cur_step), 'h10);
    repeat (10) tick();
    check("t2_step_f0", int'(cur_step), 'h10);
    tick();
    check("t2_step_new", int'(cur_step), 'h20);
    check("t2_rdy_high", int'(step_rdy), 1);
    tick();
    check("t2_step_next", int'(cur_step), 'h20);

    // 3: commit while idle, acc held at 0x20
    en = 1'b0;
    step_in = 8'h08; step_vld = 1'b1;
    tick();
    step_vld = 1'b0;
    check("t3_rdy_low", int'(step_rdy), 0);
    check("t3_step_old", int'(cur_step), 'h20);
    tick();
    check("t3_step_new", int'(cur_step), 'h08);
    check("t3_rdy_high", int'(step_rdy), 1);
    check("t3_wrap", int'(wrap), 0);
    check("t3_odd", int'(odd_sel), 1);
    check("t3_even", int'(even_sel), 1);

    // 4: clr at acc=0xA0 with a step pending and step_vld high
    en = 1'b1;
    repeat (15) tick();
    step_in = 8'h30; step_vld = 1'b1;
    tick();
    check("t4_pend", int'(step_rdy), 0);
    step_in = 8'h44; clr = 1'b1;
    tick();
    clr = 1'b0; step_vld = 1'b0; en = 1'b0;
    check("t4_rdy", int'(step_rdy), 1);
    check("t4_step", int'(cur_step), 'h08);
    tick();
    check("t4_step_idle", int'(cur_step), 'h08);

    // 5: async reset mid-run with a step pending
    en = 1'b1;
    step_in = 8'h20; step_vld = 1'b1;
    tick();
    step_vld = 1'b0;
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_step", int'(cur_step), 'h10);
    check("t5_rdy",  int'(step_rdy), 1);
    check("t5_even", int'(even_sel), 0);
    check("t5_odd",  int'(odd_sel),  0);
    check("t5_wrap", int'(wrap),     0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mixed run with sporadic step offers, checked by the model
    for (int i = 0; i < 60; i++) begin
      tick();
      step_vld = (i % 7 == 0);
      step_in  = 8'(i * 5 + 3);
      en       = (i % 11 != 5);
    end
    step_vld = 1'b0;
    en = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
